// File: rtl/bf16_pkg.sv
// Shared bfloat16 definitions for the lane packer and the MAC tree it feeds.
package bf16_pkg;

   localparam int          BF16_W    = 16;
   localparam int          MAC_LANES = 16;
   localparam logic [15:0] BF16_ZERO = 16'h0000;

   // One full vector of tree inputs; lane 0 is the least significant slice.
   typedef logic [MAC_LANES-1:0][BF16_W-1:0] lane_vec_t;

   // Occupancy of one ping-pong bank.
   typedef enum logic [1:0] {
      BANK_EMPTY   = 2'd0,
      BANK_FILLING = 2'd1,
      BANK_FULL    = 2'd2
   } bank_state_t;

endpackage

// File: rtl/bf16_lane_bank.sv
// One packing bank: lane registers, fill index, frame metadata and occupancy.
// A released bank is cleared to +0.0 in every lane, so a short frame is
// already padded when it closes.
module bf16_lane_bank
   import bf16_pkg::*;
#(
   parameter int LANES = MAC_LANES,
   parameter int W     = BF16_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en_i,
   input  logic [W-1:0]            data_i,
   input  logic                    last_i,
   input  logic                    rel_i,
   output logic                    close_o,
   output logic [LANES-1:0][W-1:0] lanes_o,
   output logic [4:0]              count_o,
   output logic                    split_o,
   output bank_state_t             state_o
);

   localparam int             IW       = $clog2(LANES);
   localparam logic [IW-1:0]  LAST_IDX = IW'(LANES - 1);
   localparam logic [W-1:0]   ZERO_W   = W'(BF16_ZERO);

   logic [LANES-1:0][W-1:0] lanes_q;
   logic [IW-1:0]           idx_q;
   logic [4:0]              count_q;
   logic [4:0]              count_d;
   logic                    split_q;
   bank_state_t             state_q;

   // The word being written closes the frame on s_last or when it fills the top lane.
   assign close_o = wr_en_i && (last_i || (idx_q == LAST_IDX));
   assign count_d = 5'(idx_q) + 5'd1;

   assign lanes_o = lanes_q;
   assign count_o = count_q;
   assign split_o = split_q;
   assign state_o = state_q;

   // Bank state machine: zero on reset/release, otherwise fill one lane per accepted word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lanes_q <= {LANES{ZERO_W}};
         idx_q   <= '0;
         count_q <= '0;
         split_q <= 1'b0;
         state_q <= BANK_EMPTY;
      end else if (rel_i) begin
         lanes_q <= {LANES{ZERO_W}};
         idx_q   <= '0;
         count_q <= '0;
         split_q <= 1'b0;
         state_q <= BANK_EMPTY;
      end else if (wr_en_i) begin
         lanes_q[idx_q] <= data_i;
         if (close_o) begin
            idx_q   <= '0;
            count_q <= count_d;
            split_q <= !last_i;
            state_q <= BANK_FULL;
         end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= BANK_FILLING;
         end
      end
   end

endmodule

// File: rtl/bf16_lane_packer.sv
// Serial-to-parallel packer: one bfloat16 word per cycle in, one 16-lane
// vector out, with two ping-pong banks so one frame fills while the other
// waits for the tree.
//
// Handshakes: a word moves when s_valid && s_ready at a rising edge; a vector
// moves when m_valid && m_ready at a rising edge. s_ready and m_valid depend
// only on registered bank state, never on m_ready or s_valid, and m_valid
// stays high with its payload frozen until it is taken.
module bf16_lane_packer
   import bf16_pkg::*;
#(
   parameter int LANES = MAC_LANES,
   parameter int W     = BF16_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [W-1:0]         s_data,
   input  logic                 s_last,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [LANES*W-1:0]   m_data,
   output logic [4:0]           m_count,
   output logic                 m_split
);

   logic                    wr_sel_q, wr_sel_d;
   logic                    rd_sel_q, rd_sel_d;
   logic                    s_fire, m_fire;
   logic                    full_a, full_b;
   logic                    close_a, close_b;
   logic [LANES-1:0][W-1:0] lanes_a, lanes_b;
   logic [4:0]              count_a, count_b;
   logic                    split_a, split_b;
   bank_state_t             state_a, state_b;

   assign full_a  = (state_a == BANK_FULL);
   assign full_b  = (state_b == BANK_FULL);

   assign s_ready = wr_sel_q ? !full_b : !full_a;
   assign m_valid = rd_sel_q ?  full_b :  full_a;
   assign s_fire  = s_valid && s_ready;
   assign m_fire  = m_valid && m_ready;

   bf16_lane_bank #(.LANES(LANES), .W(W)) u_bank_a (
      .clk     (clk),
      .rst     (rst),
      .wr_en_i (s_fire && !wr_sel_q),
      .data_i  (s_data),
      .last_i  (s_last),
      .rel_i   (m_fire && !rd_sel_q),
      .close_o (close_a),
      .lanes_o (lanes_a),
      .count_o (count_a),
      .split_o (split_a),
      .state_o (state_a)
   );

   bf16_lane_bank #(.LANES(LANES), .W(W)) u_bank_b (
      .clk     (clk),
      .rst     (rst),
      .wr_en_i (s_fire && wr_sel_q),
      .data_i  (s_data),
      .last_i  (s_last),
      .rel_i   (m_fire && rd_sel_q),
      .close_o (close_b),
      .lanes_o (lanes_b),
      .count_o (count_b),
      .split_o (split_b),
      .state_o (state_b)
   );

   // Fill side moves to the other bank on every close; read side on every transfer.
   always_comb begin
      wr_sel_d = wr_sel_q ^ (close_a | close_b);
      rd_sel_d = rd_sel_q ^ m_fire;
   end

   // Bank selectors.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_sel_q <= 1'b0;
         rd_sel_q <= 1'b0;
      end else begin
         wr_sel_q <= wr_sel_d;
         rd_sel_q <= rd_sel_d;
      end
   end

   // Present the bank selected for reading.
   always_comb begin
      m_data  = rd_sel_q ? lanes_b : lanes_a;
      m_count = rd_sel_q ? count_b : count_a;
      m_split = rd_sel_q ? split_b : split_a;
   end

endmodule
